// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame constants and baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty derive from the count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO rejects the push even if a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for an even-parity bit (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int unsigned CPB      = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CW       = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic        pop;
  logic [7:0]  fifo_rdata;
  logic        fifo_full, fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (i_valid),
    .wdata_i (i_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_count)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_rdata;
`endif
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (bit_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_rdata;
`endif
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so tx itself is a flop.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign o_ready = !fifo_full;
  assign o_busy  = (state_q != IDLE) || (o_count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: waveform-queue reference model plus a line decoder.
module tb_uart_tx;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD   = 5_000_000;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CPB    = 10;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS  = 11;
`else
  localparam int unsigned NBITS  = 10;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_ready, tx, o_busy;
  logic [3:0] o_count;

  uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .tx      (tx),
    .o_busy  (o_busy),
    .o_count (o_count)
  );

  always #5 i_clk = ~i_clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted bytes and a queue of future line levels.
  byte unsigned mq[$];
  byte unsigned acc_log[$];
  byte unsigned rx_q[$];
  bit           sq[$];
  bit           exp_tx = 1'b1;
  bit           exp_busy = 1'b0;
  bit           model_on = 1'b0;
  bit           popped, acc;
  byte unsigned fb;

  initial forever begin
    @(posedge i_clk);
    popped = 1'b0;
    if (i_rst) begin
      mq.delete();
      sq.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      model_on = 1'b1;
    end else begin
      acc = i_valid && (mq.size() < DEPTH);
      if (sq.size() == 0 && mq.size() != 0) begin
        fb = mq.pop_front();
        for (int i = 0; i < CPB; i++) sq.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int i = 0; i < CPB; i++) sq.push_back(fb[b]);
`ifdef UART_TX_PARITY_EN
        for (int i = 0; i < CPB; i++) sq.push_back(^fb);
`endif
        for (int i = 0; i < CPB; i++) sq.push_back(1'b1);
      end
      if (sq.size() != 0) begin
        exp_tx = sq.pop_front();
        popped = 1'b1;
      end else begin
        exp_tx = 1'b1;
      end
      if (acc) begin
        mq.push_back(i_data);
        acc_log.push_back(i_data);
      end
      exp_busy = popped || (mq.size() != 0);
    end
    #1;
    if (model_on) begin
      chk("m_tx",    tx,      exp_tx);
      chk("m_ready", o_ready, (mq.size() < DEPTH));
      chk("m_busy",  o_busy,  exp_busy);
      chk("m_count", o_count, mq.size());
    end
  end

  // Independent line decoder sampling mid-bit.
  byte unsigned rb;
  initial forever begin
    @(negedge i_clk);
    if (tx === 1'b0) begin
      repeat (CPB/2) @(negedge i_clk);
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(negedge i_clk);
        rb[b] = tx;
      end
      repeat (CPB*(NBITS-9)) @(negedge i_clk);
      rx_q.push_back(rb);
    end
  end

  task automatic wait_idle(input int unsigned max);
    int unsigned n = 0;
    while (o_busy !== 1'b0 && n < max) begin
      @(negedge i_clk);
      n++;
    end
    chk("idle_timeout", (n < max), 1);
    repeat (5) @(negedge i_clk);
  endtask

  task automatic push_seq(input byte unsigned b);
    i_data  = b;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  byte unsigned s3[3] = '{8'hA3, 8'h0F, 8'hFF};
  byte unsigned s6[6];

  initial begin
    int unsigned n;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;

    // Idle after reset
    repeat (100) @(negedge i_clk);
    chk("idle_tx", tx, 1);
    chk("idle_ready", o_ready, 1);
    chk("idle_busy", o_busy, 0);
    chk("idle_count", o_count, 0);

    // Single 0x55 frame with hand-computed bit times
    rx_q.delete();
    push_seq(8'h55);
    chk("s2_count", o_count, 1);
    chk("s2_pre_start", tx, 1);
    @(negedge i_clk);
    chk("s2_start", tx, 0);
    repeat (10) @(negedge i_clk);
    chk("s2_bit0", tx, 1);
    repeat (10) @(negedge i_clk);
    chk("s2_bit1", tx, 0);
    repeat (70) @(negedge i_clk);
`ifdef UART_TX_PARITY_EN
    chk("s2_parity", tx, 0);
    repeat (10) @(negedge i_clk);
`endif
    chk("s2_stop", tx, 1);
    repeat (9) @(negedge i_clk);
    chk("s2_busy_last_stop", o_busy, 1);
    @(negedge i_clk);
    chk("s2_busy_after", o_busy, 0);
    repeat (5) @(negedge i_clk);
    chk("s2_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("s2_rx", rx_q[0], 8'h55);

    // Three back-to-back bytes
    rx_q.delete();
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_data = s3[k];
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    wait_idle(1000);
    chk("s3_rx_n", rx_q.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < rx_q.size()) chk("s3_rx", rx_q[k], s3[k]);

    // Overfill: 0x19 dropped while full, resent once ready returns
    rx_q.delete();
    push_seq(8'h00);
    @(negedge i_clk);
    i_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      i_data = 8'(8'h11 + k);
      if (k == 8) begin
        chk("s4_full_count", o_count, 8);
        chk("s4_full_ready", o_ready, 0);
      end
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    chk("s4_count_after_drop", o_count, 8);
    n = 0;
    while (o_ready !== 1'b1 && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    chk("s4_ready_timeout", (n < 500), 1);
    push_seq(8'h19);
    wait_idle(3000);
    chk("s4_rx_n", rx_q.size(), 10);
    if (rx_q.size() > 0) chk("s4_rx0", rx_q[0], 8'h00);
    for (int k = 1; k < 10; k++)
      if (k < rx_q.size()) chk("s4_rx", rx_q[k], 8'(8'h10 + k));

    // Reset mid-DATA with bytes queued
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data = 8'(k);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    repeat (30) @(negedge i_clk);
    chk("s5_queued", o_count, 3);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("s5_tx", tx, 1);
    chk("s5_count", o_count, 0);
    chk("s5_busy", o_busy, 0);
    repeat (300) @(negedge i_clk);
    chk("s5_tx_quiet", tx, 1);
    chk("s5_busy_quiet", o_busy, 0);

    // Push coinciding with pop at count 4
    rx_q.delete();
    for (int k = 0; k < 6; k++) s6[k] = 8'($urandom);
    i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_data = s6[k];
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    chk("s6_count4", o_count, 4);
    repeat (NBITS*CPB - 4) @(negedge i_clk);
    push_seq(s6[5]);
    chk("s6_count_same", o_count, 4);
    chk("s6_next_start", tx, 0);
    wait_idle(2000);
    chk("s6_rx_n", rx_q.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < rx_q.size()) chk("s6_rx", rx_q[k], s6[k]);

    // Random bursty traffic
    rx_q.delete();
    acc_log.delete();
    for (int c = 0; c < 4000; c++) begin
      i_valid = ($urandom_range(0, 99) < (((c / 500) % 2 == 1) ? 4 : 70));
      i_data  = 8'($urandom);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    wait_idle(3000);
    chk("rand_rx_n", rx_q.size(), acc_log.size());
    for (int k = 0; k < acc_log.size(); k++)
      if (k < rx_q.size()) chk("rand_rx", rx_q[k], acc_log[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter serialising bytes from the `cpu` onto the `tx` pin of the `LEG` top level, at 8 data bits, LSB first, 1 stop bit. It is the transmit-side counterpart of the CPU's UART receive path. A small synchronous FIFO decouples the CPU write handshake from the bit-serial line, so the CPU can burst several bytes without stalling. The block runs entirely in the `pll_clk` domain.

## Interface
- `CLK_HZ`, default 50_000_000, input clock frequency in Hz.
- `BAUD`, default 115_200, line rate in bits/s.
- `FIFO_DEPTH`, default 8, number of byte entries; must be a power of two and at least 2.

- `i_clk` input 1: the only clock. All logic is on its rising edge.
- `i_rst` input 1: reset, synchronous and active-high.
- `i_data` input 8: byte to transmit.
- `i_valid` input 1: `i_data` is valid this cycle.
- `o_ready` output 1: the FIFO can accept a byte.
- `tx` output 1: serial line; idle high.
- `o_busy` output 1: a frame is on the line or the FIFO is non-empty.
- `o_count` output $clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- Push occurs when `i_valid && o_ready` at a rising edge. `o_ready = !full`, derived from the registered count. A push attempted while full is dropped, with no error flag.
- `CLKS_PER_BIT = CLK_HZ / BAUD` (integer division). The bit counter is `$clog2(CLKS_PER_BIT)` wide and counts 0..CLKS_PER_BIT-1.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit, shifting right. After 8 bits, go to PARITY if enabled, otherwise STOP.
  - PARITY: only with the macro defined (see Configuration).
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Simultaneous push and pop is legal and leaves `o_count` unchanged. When the FIFO is full, a pop in the same cycle does not make that cycle's push acceptable.
- `o_busy = (state != IDLE) || (o_count != 0)`.
- Reset values: `tx`=1, `o_ready`=1, `o_busy`=0, `o_count`=0, state IDLE, FIFO pointers 0.
- Reset asserted mid-frame: at the next edge `tx`=1 and the FIFO is emptied. The truncated frame is not resumed.

## Timing
- Push into an empty FIFO at edge N: `o_count`=1 after N. The FSM pops at N+1, and `tx` goes low after edge N+1.
- The start-bit falling edge is registered, so `tx` is glitch-free (it is a flop output).
- Frame length is 10×CLKS_PER_BIT cycles (11× with parity).
- Back-to-back frames: the next start bit follows the stop bit with zero idle cycles.
- `o_ready` deasserts the cycle after the push that fills the FIFO.

## Configuration
- `UART_TX_PARITY_EN` defined: an even-parity bit (the XOR of the 8 data bits) is sent in state PARITY for CLKS_PER_BIT cycles, between DATA and STOP.
- Not defined: the PARITY state and its logic are absent, and the frame is 8N1.

## Structure
- Package `uart_pkg` contains:
  - the `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - the `DATA_BITS=8` constant;
  - a `clks_per_bit(clk_hz, baud)` function shared with the receiver.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) provides push/pop, full, empty and count. `uart_tx` instantiates it with WIDTH=8.

## Test plan
All scenarios use CLK_HZ=50_000_000 and BAUD=5_000_000, giving CLKS_PER_BIT=10.
- Reset, then idle for 100 cycles -> `tx`=1, `o_ready`=1, `o_busy`=0, `o_count`=0 throughout.
- Push 0x55 -> `tx` low 2 cycles after `i_valid` rises, then bits 1,0,1,0,1,0,1,0 for 10 cycles each, then stop 1. `o_busy` is 0 one cycle after the stop bit ends. With `UART_TX_PARITY_EN`, a parity bit of 0 precedes stop.
- Push 0xA3, 0x0F, 0xFF on consecutive cycles -> three frames with no idle gap. Decoded bytes are 0xA3, 0x0F, 0xFF in order.
- Hold `i_valid` with 0x11..0x19 (nine bytes) while the line is busy, with FIFO_DEPTH=8 -> `o_ready` drops at count 8. 0x19 is dropped unless it is presented once `o_ready` is 1 again.
- Assert `i_rst` for 1 cycle mid-DATA of a 0x00 frame with 3 bytes queued -> `tx`=1 the next cycle, `o_count`=0, and no further frames.
- Push and pop in the same cycle with count 4 -> count stays 4, and the popped byte's start bit begins the next cycle.
